// File: rtl/qpu_tevq_dispatch_pkg.sv
// Shared QPU definitions for the time/event queue dispatcher.
// Widths default from the QPU width macros; FSM state encodings.
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 32
`endif
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 32
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 16
`endif

package qpu_tevq_dispatch_pkg;

    localparam int QPU_TIME_W  = `QPU_TIME_WIDTH;
    localparam int QPU_EVT_W   = `QPU_EVENT_WIRE_WIDTH;
    localparam int QPU_EVT_NUM = `QPU_EVENT_NUM;
    localparam int LATE_CNT_W  = 8;

    typedef enum logic {
        QPU_TEVQ_IDLE = 1'b0,
        QPU_TEVQ_WAIT = 1'b1
    } tevq_state_t;

endpackage

// File: rtl/qpu_sys_timer.sv
// QPU system timer: saturating up-counter with run enable and clear.
// Ports: clk, rst_n (sync, active-low), run, clr (priority), count.
module qpu_sys_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (clr) begin
            count_d = '0;
        end else if (run && (count != '1)) begin
            count_d = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/qpu_tevq_dispatch.sv
// Time/event queue dispatcher: pops tiq/evq pairs, holds each until the
// system timer reaches its time point, then strobes it onto the event bus.
// Ports: clk, rst_n (sync, active-low), run_i, clr_i; tiq/evq read side
// (valid/ready/data, shared ready); evt_o_* fire strobe; timer_o; busy_o.
// Optional macro QPU_TEVQ_LATE_CHK_EN adds late_err_o and late_cnt_o.
module qpu_tevq_dispatch
    import qpu_tevq_dispatch_pkg::*;
#(
    parameter int TIME_W  = QPU_TIME_W,
    parameter int EVT_W   = QPU_EVT_W,
    parameter int EVT_NUM = QPU_EVT_NUM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic               clr_i,
    input  logic               tiq_rd_valid_i,
    output logic               tiq_rd_ready_o,
    input  logic [TIME_W-1:0]  tiq_rd_data_i,
    input  logic               evq_rd_valid_i,
    output logic               evq_rd_ready_o,
    input  logic [EVT_W-1:0]   evq_rd_data_i,
    input  logic [EVT_NUM-1:0] evq_rd_oprand_i,
    output logic               evt_o_valid,
    output logic [EVT_W-1:0]   evt_o_data,
    output logic [EVT_NUM-1:0] evt_o_oprand,
`ifdef QPU_TEVQ_LATE_CHK_EN
    output logic                  late_err_o,
    output logic [LATE_CNT_W-1:0] late_cnt_o,
`endif
    output logic [TIME_W-1:0]  timer_o,
    output logic               busy_o
);

    logic [TIME_W-1:0]  timer_q;
    tevq_state_t        state_q;
    tevq_state_t        state_d;
    logic [TIME_W-1:0]  tp_q;
    logic [EVT_W-1:0]   evt_q;
    logic [EVT_NUM-1:0] opr_q;
    logic               fire;
    logic               pop;

    qpu_sys_timer #(
        .W (TIME_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_i),
        .clr   (clr_i),
        .count (timer_q)
    );

    always_comb begin
        fire    = 1'b0;
        pop     = 1'b0;
        state_d = state_q;
        unique case (1'b1)
            (state_q == QPU_TEVQ_WAIT): begin
                fire = run_i && !clr_i && (timer_q >= tp_q);
            end
            default: begin
                fire = 1'b0;
            end
        endcase
        // Pop only a complete pair, and only when the slot is free
        // or being vacated by this cycle's fire.
        pop = tiq_rd_valid_i && evq_rd_valid_i && !clr_i &&
              ((state_q == QPU_TEVQ_IDLE) || fire);
        if (clr_i) begin
            state_d = QPU_TEVQ_IDLE;
        end else if (pop) begin
            state_d = QPU_TEVQ_WAIT;
        end else if (fire) begin
            state_d = QPU_TEVQ_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= QPU_TEVQ_IDLE;
            tp_q    <= '0;
            evt_q   <= '0;
            opr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_i) begin
                tp_q  <= '0;
                evt_q <= '0;
                opr_q <= '0;
            end else if (pop) begin
                tp_q  <= tiq_rd_data_i;
                evt_q <= evq_rd_data_i;
                opr_q <= evq_rd_oprand_i;
            end
        end
    end

    assign tiq_rd_ready_o = pop;
    assign evq_rd_ready_o = pop;
    assign evt_o_valid    = fire;
    assign evt_o_data     = fire ? evt_q : '0;
    assign evt_o_oprand   = fire ? opr_q : '0;
    assign timer_o        = timer_q;
    assign busy_o         = (state_q == QPU_TEVQ_WAIT);

`ifdef QPU_TEVQ_LATE_CHK_EN
    logic                  late;
    logic                  late_err_q;
    logic [LATE_CNT_W-1:0] late_cnt_q;

    // Compare against the post-edge timer. A pop never coincides with
    // clr, so that value is timer_q plus run_i; the extra bit makes the
    // saturated case (timer all-ones) come out right without wrapping.
    assign late = pop &&
        ({1'b0, tiq_rd_data_i} <=
         ({1'b0, timer_q} + {{TIME_W{1'b0}}, run_i}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            late_err_q <= 1'b0;
            late_cnt_q <= '0;
        end else if (clr_i) begin
            late_err_q <= 1'b0;
            late_cnt_q <= '0;
        end else if (late) begin
            late_err_q <= 1'b1;
            if (late_cnt_q != '1) begin
                late_cnt_q <= late_cnt_q + 1'b1;
            end
        end
    end

    assign late_err_o = late_err_q;
    assign late_cnt_o = late_cnt_q;
`endif

endmodule

// File: tb/tb_qpu_tevq_dispatch.sv
// Self-checking bench for qpu_tevq_dispatch: directed scenarios plus
// random traffic, scoreboarded against a queue-level reference model.
module tb_qpu_tevq_dispatch;

    localparam int TW = 8;
    localparam int EW = 16;
    localparam int ON = 8;
    localparam int TMAX = (1 << TW) - 1;

    typedef struct packed {
        logic [EW-1:0] evt;
        logic [ON-1:0] opr;
    } ev_t;

    typedef struct packed {
        logic [TW-1:0] tp;
        logic [EW-1:0] evt;
        logic [ON-1:0] opr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          clr;
    logic          tiq_v;
    logic          tiq_rdy;
    logic [TW-1:0] tiq_d;
    logic          evq_v;
    logic          evq_rdy;
    logic [EW-1:0] evq_d;
    logic [ON-1:0] evq_o;
    logic          evt_v;
    logic [EW-1:0] evt_d;
    logic [ON-1:0] evt_op;
    logic [TW-1:0] timer;
    logic          busy;
`ifdef QPU_TEVQ_LATE_CHK_EN
    logic          late_err;
    logic [7:0]    late_cnt;
`endif

    qpu_tevq_dispatch #(
        .TIME_W  (TW),
        .EVT_W   (EW),
        .EVT_NUM (ON)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run_i           (run),
        .clr_i           (clr),
        .tiq_rd_valid_i  (tiq_v),
        .tiq_rd_ready_o  (tiq_rdy),
        .tiq_rd_data_i   (tiq_d),
        .evq_rd_valid_i  (evq_v),
        .evq_rd_ready_o  (evq_rdy),
        .evq_rd_data_i   (evq_d),
        .evq_rd_oprand_i (evq_o),
        .evt_o_valid     (evt_v),
        .evt_o_data      (evt_d),
        .evt_o_oprand    (evt_op),
`ifdef QPU_TEVQ_LATE_CHK_EN
        .late_err_o      (late_err),
        .late_cnt_o      (late_cnt),
`endif
        .timer_o         (timer),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Queue contents owned by the bench, plus the expected fire order.
    logic [TW-1:0] tiq_m[$];
    ev_t           evq_m[$];
    exp_t          exp_q[$];

    // Reference model state.
    int   m_timer;
    bit   m_held;
    int   m_tp;
    bit   m_late_err;
    int   m_late_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act,
                       input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h want %0h at t=%0t",
                      name, act, req, $time);
    endtask

    function automatic void refresh();
        tiq_v = (tiq_m.size() != 0);
        tiq_d = tiq_v ? tiq_m[0] : '0;
        evq_v = (evq_m.size() != 0);
        evq_d = evq_v ? evq_m[0].evt : '0;
        evq_o = evq_v ? evq_m[0].opr : '0;
    endfunction

    function automatic void flush();
        tiq_m.delete();
        evq_m.delete();
        exp_q.delete();
    endfunction

    // Advance the model across one clock edge using the inputs that
    // were stable during the cycle that just ended.
    function automatic void model_step();
        bit f;
        bit p;
        int nt;
        if (!rst_n || clr) begin
            m_timer    = 0;
            m_held     = 0;
            m_tp       = 0;
            m_late_err = 0;
            m_late_cnt = 0;
            flush();
            return;
        end
        f  = m_held && run && (m_timer >= m_tp);
        p  = (tiq_m.size() > 0) && (evq_m.size() > 0) && (!m_held || f);
        nt = run ? ((m_timer == TMAX) ? TMAX : m_timer + 1) : m_timer;
        if (p) begin
            m_tp   = int'(tiq_m.pop_front());
            void'(evq_m.pop_front());
            m_held = 1;
            if (m_tp <= nt) begin
                m_late_err = 1;
                if (m_late_cnt < 255) m_late_cnt++;
            end
        end else if (f) begin
            m_held = 0;
        end
        m_timer = nt;
    endfunction

    task automatic compare();
        bit   ef;
        bit   ep;
        exp_t e;
        ef = m_held && run && !clr && (m_timer >= m_tp);
        ep = (tiq_m.size() > 0) && (evq_m.size() > 0) &&
             (!m_held || ef) && !clr;
        chk("timer", timer, m_timer);
        chk("busy", busy, m_held);
        chk("fire", evt_v, ef);
        chk("tiq_ready", tiq_rdy, ep);
        chk("evq_ready", evq_rdy, ep);
        if (evt_v) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("evt_data", evt_d, e.evt);
                chk("evt_oprand", evt_op, e.opr);
                chk("fire_not_early", (timer >= e.tp), 1);
            end
        end else begin
            chk("idle_bus", {evt_d, evt_op}, 0);
        end
`ifdef QPU_TEVQ_LATE_CHK_EN
        chk("late_err", late_err, m_late_err);
        chk("late_cnt", late_cnt, m_late_cnt);
`endif
    endtask

    // Monitor: model update just after each edge, compare mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            refresh();
            @(negedge clk);
            compare();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int tp, input int ev, input int op);
        exp_t e;
        ev_t  v;
        v.evt = EW'(ev);
        v.opr = ON'(op);
        e.tp  = TW'(tp);
        e.evt = v.evt;
        e.opr = v.opr;
        tiq_m.push_back(TW'(tp));
        evq_m.push_back(v);
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_held) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, exp_q.size(), 0);
    endtask

    task automatic wait_timer(input int t, input int budget);
        int n;
        n = 0;
        while (m_timer != t && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_timer_timeout", m_timer, t);
    endtask

    initial begin
        ev_t v;
        exp_t e;
        int  t;
        rst_n = 1'b0;
        run   = 1'b0;
        clr   = 1'b0;
        refresh();
        repeat (3) tick();
        rst_n = 1'b1;

        // Basic fire.
        run = 1'b1;
        push(10, 'hA5, 'h3);
        wait_drain("basic", 40);

        // Back-to-back with equal time points.
        pulse_clr();
        push(5, 'h0E1, 'h01);
        push(5, 'h0E2, 'h02);
        push(6, 'h0E3, 'h04);
        wait_drain("b2b", 40);
        repeat (2) tick();

        // Late entry.
        wait_timer(20, 40);
        push(12, 'h1234, 'h80);
        wait_drain("late", 10);

        // Freeze mid-WAIT.
        pulse_clr();
        push(8, 'hBEEF, 'h55);
        wait_timer(6, 20);
        run = 1'b0;
        repeat (4) tick();
        run = 1'b1;
        wait_drain("freeze", 20);

        // Queue mismatch: tiq only for three cycles.
        pulse_clr();
        tiq_m.push_back(TW'(30));
        refresh();
        repeat (3) tick();
        v.evt = 'h7777;
        v.opr = 'h0F;
        e.tp  = TW'(30);
        e.evt = v.evt;
        e.opr = v.opr;
        evq_m.push_back(v);
        exp_q.push_back(e);
        refresh();
        wait_drain("mismatch", 60);

        // Clear mid-WAIT.
        pulse_clr();
        push(100, 'hC1C1, 'h11);
        wait_timer(40, 60);
        pulse_clr();
        repeat (3) tick();

        // Reset mid-WAIT.
        push(100, 'hD2D2, 'h22);
        wait_timer(20, 40);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Timer saturation.
        run = 1'b1;
        repeat (270) tick();
        push(250, 'h5A5A, 'hA0);
        push(255, 'h6B6B, 'hB0);
        wait_drain("sat", 10);

        // Random traffic.
        pulse_clr();
        for (int i = 0; i < 1500; i++) begin
            run = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 199) == 0);
            if (tiq_m.size() < 8 && $urandom_range(0, 9) < 4) begin
                t = m_timer + int'($urandom_range(0, 20));
                if ($urandom_range(0, 7) == 0) t = int'($urandom_range(0, TMAX));
                if (t > TMAX) t = TMAX;
                push(t, int'($urandom_range(0, 'hFFFF)),
                     int'($urandom_range(0, 'hFF)));
            end
            tick();
        end
        clr = 1'b0;
        run = 1'b1;
        wait_drain("final", 800);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qpu_tevq_dispatch.md
Name: qpu_tevq_dispatch

Overview:
- Scheduler that drains the time queue (tiq) and event queue (evq) filled by the EXU write-back stage.
- Each tiq entry holds an absolute time point and pairs 1:1 with the evq entry at the same queue position.
- The block runs the QPU system timer, pops each pair, holds it until the timer reaches the time point, then fires the event onto the codeword/event bus.
- Sits between the tiq/evq FIFOs and the quantum control outputs.

Parameters:
- TIME_W, default `QPU_TIME_WIDTH: width of time points and the system timer.
- EVT_W, default `QPU_EVENT_WIRE_WIDTH: event payload width.
- EVT_NUM, default `QPU_EVENT_NUM: operand (qubit mask) width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- run_i  in  1  1 = timer counts and firing is enabled; 0 = both frozen.
- clr_i  in  1  synchronous clear of timer and scheduler state.
- tiq_rd_valid_i  in  1  tiq non-empty.
- tiq_rd_ready_o  out  1  pop tiq this cycle.
- tiq_rd_data_i  in  TIME_W  head time point.
- evq_rd_valid_i  in  1  evq non-empty.
- evq_rd_ready_o  out  1  pop evq this cycle; always equal to tiq_rd_ready_o.
- evq_rd_data_i  in  EVT_W  head event payload.
- evq_rd_oprand_i  in  EVT_NUM  head operand mask.
- evt_o_valid  out  1  one-cycle fire strobe; no backpressure.
- evt_o_data  out  EVT_W  fired payload.
- evt_o_oprand  out  EVT_NUM  fired operand mask.
- timer_o  out  TIME_W  current timer value (timer_q).
- busy_o  out  1  an entry is latched (state WAIT).

Behaviour:
- Reset (rst_n=0 at clk edge), all outputs and state:
  - timer_q=0, state=IDLE.
  - Latched tp_q / evt_q / opr_q = 0.
  - All outputs 0.
- Timer:
  - If clr_i: timer_q <= 0.
  - Else if run_i: timer_q <= timer_q+1, saturating at all-ones (no wrap).
  - clr_i has priority over run_i.
- States: IDLE, WAIT.
- pop = both valid AND (state==IDLE OR fire) AND ~clr_i.
  - tiq_rd_ready_o = evq_rd_ready_o = pop.
  - Never pop when only one queue is valid.
- IDLE:
  - pop=1 -> latch tiq/evq heads into tp_q/evt_q/opr_q, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - fire = run_i AND (timer_q >= tp_q), unsigned compare.
  - evt_o_valid = fire, combinational from registers. evt_o_data/evt_o_oprand = evt_q/opr_q while fire, else 0.
  - fire AND pop: latch next pair, stay in WAIT (back-to-back).
  - fire without pop: go to IDLE.
  - No fire: hold.
- Latency:
  - Entry present in IDLE at cycle N -> latched at edge N+1.
  - Earliest fire in cycle N+1, i.e. the cycle in which timer_o == tp.
  - A past time point (tp <= timer_q at latch) fires in the first WAIT cycle.
- Two events with equal time points fire on consecutive cycles. Events are never merged or dropped.
- run_i=0 in WAIT: no fire, entry held, timer frozen. Popping from IDLE is still allowed.
- clr_i (at any state, including mid-WAIT):
  - state <= IDLE, latched entry discarded, timer <= 0.
  - No fire and no pop in that cycle.
  - Queue flush is the queue owner's job.
- busy_o = (state==WAIT).

Optional Feature:
- Macro QPU_TEVQ_LATE_CHK_EN.
- Defined:
  - Adds output late_err_o (1 bit, sticky) and an 8-bit saturating counter late_cnt_o.
  - A pair is late if, in the cycle it is latched, tp <= the timer value after that edge's increment. Use the next-timer value, not timer_q.
  - Each late latch sets late_err_o and increments late_cnt_o.
  - Both are cleared by reset or clr_i. The late event still fires.
- Undefined: the ports and logic are absent; fire behaviour is identical.

Decomposition:
- Shared QPU_defines: state encodings QPU_TEVQ_IDLE=1'b0, QPU_TEVQ_WAIT=1'b1, plus the existing time/event width macros.
- One natural sub-module: qpu_sys_timer (saturating counter with run/clr), reusable by the measurement unit.

Test Plan:
- Basic fire: run_i=1 from timer 0; push tp=10 with evt=0xA5, oprand=0x3 -> evt_o_valid exactly in the cycle timer_o==10, data 0xA5, oprand 0x3, single pulse.
- Back-to-back: push tp=5, tp=5, tp=6 with events E1, E2, E3 -> fires at timer 5, 6, 7 (in order, no gaps), busy_o drops the cycle after E3.
- Late entry: timer at 20, push tp=12 -> fires on the first WAIT cycle. With QPU_TEVQ_LATE_CHK_EN, late_err_o=1 and late_cnt_o=1.
- Freeze: latch tp=8, drop run_i at timer 6 for 4 cycles -> timer_o holds 6, no fire; resume -> fires at timer 8.
- Queue mismatch: tiq valid, evq empty for 3 cycles -> ready stays 0, state IDLE; evq becomes valid -> pop on that cycle.
- Clear mid-WAIT: tp=100 latched, timer 40, pulse clr_i -> next cycle timer_o=0, busy_o=0, no fire, no pop in clr cycle. Assert rst_n=0 mid-WAIT likewise -> all outputs 0 next edge.
